// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and the pipeline registers
// that feed it. Holds the address/data widths, the zero word, the NOP
// destination address, and the write/read enable encodings.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_data_t ZERO_WORD    = 32'h00000000;
    localparam reg_addr_t NOP_REG_ADDR = 5'b00000;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/regfile_if.sv
// Bus between the write-back/decode stages and the register file.
// Signals:
//   we, waddr, wdata     write-back triple (one write offered per cycle)
//   re1/raddr1, re2/raddr2  read-port enables/addresses from decode
//   rdata1, rdata2       combinational read data (with write bypass)
//   dbg_addr, dbg_data   raw array read for bring-up (no bypass)
//   wcount               retired-write counter, CNT_W bits
// Handshake: there is no valid/ready pair. A write is offered whenever we=1
// and is always accepted at the next posedge (no back-pressure); reads are
// enable-qualified and answered in the same cycle.
// Modports: master = the pipeline side, slave = the register file.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int CNT_W = 32
) ();
    logic             we;
    reg_addr_t        waddr;
    reg_data_t        wdata;
    logic             re1;
    reg_addr_t        raddr1;
    reg_data_t        rdata1;
    logic             re2;
    reg_addr_t        raddr2;
    reg_data_t        rdata2;
    reg_addr_t        dbg_addr;
    reg_data_t        dbg_data;
    logic [CNT_W-1:0] wcount;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, wcount
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, wcount
    );
endinterface

// File: rtl/regfile_rport.sv
// One read port of the register file: priority mux selecting between zero,
// the in-flight write data (bypass) and the stored array value.
// Ports:
//   rst          reset level; forces the output to zero
//   re, raddr    port enable and address
//   we, waddr, wdata  write-back triple used for the bypass compare
//   stored       array contents at raddr (zero for address 0)
//   rdata        resulting read data
module regfile_rport
    import regfile_pkg::*;
(
    input  logic      rst,
    input  logic      re,
    input  reg_addr_t raddr,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_data_t wdata,
    input  reg_data_t stored,
    output reg_data_t rdata
);

    // Order matters: reset and disable win over everything, r0 wins over
    // the bypass so a write aimed at r0 can never leak onto a read port.
    always_comb begin
        rdata = ZERO_WORD;
        if (rst) begin
            rdata = ZERO_WORD;
        end else if (re == READ_DISABLE) begin
            rdata = ZERO_WORD;
        end else if (raddr == NOP_REG_ADDR) begin
            rdata = ZERO_WORD;
        end else if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
            rdata = wdata;
        end else begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file at the end of the write-back path.
// Registers 1..REG_NUM-1 hold REG_DATA_W-bit values; register 0 has no
// storage and reads as zero. Two combinational read ports with same-cycle
// write bypass, a raw debug read port and a retired-write counter.
// Ports:
//   clk   clock, all state changes on posedge
//   rst   asynchronous active-high reset (clears array and counter)
//   bus   regfile_if slave modport (write triple, read ports, debug, wcount)
module regfile
    import regfile_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 32
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    reg_data_t        mem [1:REG_NUM-1];
    logic [CNT_W-1:0] wcount_q;
    logic             wr_accept;
    reg_data_t        stored1;
    reg_data_t        stored2;
    reg_data_t        dbg_word;

    // Writes to r0 are dropped entirely, including from the counter.
    assign wr_accept = (bus.we == WRITE_ENABLE) && (bus.waddr != NOP_REG_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                mem[i] <= ZERO_WORD;
            end
            wcount_q <= '0;
        end else if (wr_accept) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (bus.waddr == reg_addr_t'(i)) begin
                    mem[i] <= bus.wdata;
                end
            end
            wcount_q <= wcount_q + CNT_W'(1);
        end
    end

    // Array lookups; address 0 falls through to the zero default since
    // there is no entry for it.
    always_comb begin
        stored1  = ZERO_WORD;
        stored2  = ZERO_WORD;
        dbg_word = ZERO_WORD;
        for (int i = 1; i < REG_NUM; i++) begin
            if (bus.raddr1 == reg_addr_t'(i)) stored1 = mem[i];
            if (bus.raddr2 == reg_addr_t'(i)) stored2 = mem[i];
            if (bus.dbg_addr == reg_addr_t'(i)) dbg_word = mem[i];
        end
    end

    regfile_rport u_rport1 (
        .rst    (rst),
        .re     (bus.re1),
        .raddr  (bus.raddr1),
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .stored (stored1),
        .rdata  (bus.rdata1)
    );

    regfile_rport u_rport2 (
        .rst    (rst),
        .re     (bus.re2),
        .raddr  (bus.raddr2),
        .we     (bus.we),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .stored (stored2),
        .rdata  (bus.rdata2)
    );

    // Debug port shows the raw array; it is zero in reset only because the
    // array itself is cleared.
    assign bus.dbg_data = dbg_word;
    assign bus.wcount   = wcount_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a main instance (CNT_W=32) and a CNT_W=4
// instance sharing the same stimulus, a behavioural model checked every
// negedge, and hand-computed literal checks.
module tb_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    regfile_if #(.CNT_W(32)) bus ();
    regfile_if #(.CNT_W(4))  bus4 ();

    regfile #(.REG_NUM(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    regfile #(.REG_NUM(32), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.we       = bus.we;
    assign bus4.waddr    = bus.waddr;
    assign bus4.wdata    = bus.wdata;
    assign bus4.re1      = bus.re1;
    assign bus4.raddr1   = bus.raddr1;
    assign bus4.re2      = bus.re2;
    assign bus4.raddr2   = bus.raddr2;
    assign bus4.dbg_addr = bus.dbg_addr;

    // ---------------- clock ----------------
    initial forever #50 clk = ~clk;

    // ---------------- model ----------------
    logic [31:0] model_mem [32];
    int unsigned model_count;
    logic [31:0] exp_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
            model_count = 0;
        end else if (bus.we && bus.waddr != 5'd0) begin
            model_mem[bus.waddr] = bus.wdata;
            model_count = model_count + 1;
        end
    end

    function automatic logic [31:0] model_read(input logic r, input logic en,
                                               input logic [4:0] a);
        if (r) return 32'h0;
        if (!en) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (bus.we && bus.waddr == a) return bus.wdata;
        return model_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every negedge.
    always @(negedge clk) begin
        check("cmp_rdata1", bus.rdata1, model_read(rst, bus.re1, bus.raddr1));
        check("cmp_rdata2", bus.rdata2, model_read(rst, bus.re2, bus.raddr2));
        check("cmp_dbg", bus.dbg_data,
              (bus.dbg_addr == 5'd0) ? 32'h0 : model_mem[bus.dbg_addr]);
        check("cmp_wcount", bus.wcount, model_count);
        check("cmp_wcount4", {28'h0, bus4.wcount}, {28'h0, model_count[3:0]});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        tick();
        bus.we    = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
        bus.re1 = 1'b0; bus.raddr1 = 5'd0;
        bus.re2 = 1'b0; bus.raddr2 = 5'd0;
        bus.dbg_addr = 5'd0;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        #1;
        check("por_wcount", bus.wcount, 32'h0);
        check("por_rdata1", bus.rdata1, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Preload some state so the reset pulse has something to clear
        write(5'd3, 32'h11111111);
        write(5'd4, 32'h22222222);
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        bus.re2 = 1'b1; bus.raddr2 = 5'd4;
        #10;
        check("pre_rdata1", bus.rdata1, 32'h11111111);
        check("pre_rdata2", bus.rdata2, 32'h22222222);

        // Reset pulse between edges: everything must clear before next posedge
        tick();
        #1 rst = 1'b1;
        #1;
        check("rst_wcount", bus.wcount, 32'h0);
        check("rst_rdata1", bus.rdata1, 32'h0);
        check("rst_rdata2", bus.rdata2, 32'h0);
        for (int a = 0; a < 32; a++) begin
            bus.dbg_addr = 5'(a);
            #1;
            check("rst_dbg", bus.dbg_data, 32'h0);
        end
        #2 rst = 1'b0;
        tick();

        // Basic write/read
        write(5'd5, 32'hDEADBEEF);
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        bus.dbg_addr = 5'd5;
        #10;
        check("basic_rdata1", bus.rdata1, 32'hDEADBEEF);
        check("basic_wcount", bus.wcount, 32'd1);
        check("basic_dbg", bus.dbg_data, 32'hDEADBEEF);

        // Bypass on both ports, debug port still shows old value
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h12345678;
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        bus.dbg_addr = 5'd7;
        #10;
        check("byp_rdata1", bus.rdata1, 32'h12345678);
        check("byp_rdata2", bus.rdata2, 32'h12345678);
        check("byp_dbg_old", bus.dbg_data, 32'h0);
        tick();
        bus.we = 1'b0;
        #10;
        check("byp_dbg_new", bus.dbg_data, 32'h12345678);
        check("byp_wcount", bus.wcount, 32'd2);

        // r0 immutability
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        bus.dbg_addr = 5'd0;
        #10;
        check("r0_rdata1_same", bus.rdata1, 32'h0);
        tick();
        bus.we = 1'b0;
        #10;
        check("r0_rdata1_next", bus.rdata1, 32'h0);
        check("r0_wcount", bus.wcount, 32'd2);
        check("r0_dbg", bus.dbg_data, 32'h0);

        // Read-enable gating
        bus.re2 = 1'b0; bus.raddr2 = 5'd5;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        #10;
        check("gate_rdata2", bus.rdata2, 32'h0);
        check("gate_rdata1", bus.rdata1, 32'hDEADBEEF);
        tick();

        // Reset asserted during a write to r9: the write is lost
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hA5A5A5A5;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.we = 1'b0;
        bus.re1 = 1'b1; bus.raddr1 = 5'd9;
        bus.dbg_addr = 5'd9;
        #10;
        check("mwr_rdata1", bus.rdata1, 32'h0);
        check("mwr_dbg", bus.dbg_data, 32'h0);
        check("mwr_wcount", bus.wcount, 32'h0);
        write(5'd9, 32'hA5A5A5A5);
        #10;
        check("mwr_rewrite_dbg", bus.dbg_data, 32'hA5A5A5A5);
        check("mwr_rewrite_wcount", bus.wcount, 32'd1);

        // 16 more accepted writes (17 since reset) plus an ignored r0 write;
        // first two target r12 back-to-back.
        for (int i = 0; i < 16; i++) begin
            logic [4:0] a;
            logic [31:0] d;
            a = (i < 2) ? 5'd12 : 5'(20 + (i % 8));
            d = 32'h10000000 + 32'(i);
            exp_q.push_back(d);
            write(a, d);
            bus.dbg_addr = a;
            #10;
            check("seq_dbg", bus.dbg_data, exp_q.pop_front());
            if (i == 5) write(5'd0, 32'hCAFEF00D);
        end
        bus.dbg_addr = 5'd12;
        #10;
        check("b2b_r12", bus.dbg_data, 32'h10000001);
        check("wrap_wcount32", bus.wcount, 32'd17);
        check("wrap_wcount4", {28'h0, bus4.wcount}, 32'd1);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

- Architectural register file at the receiving end of the write-back path.
- Each clock, it consumes the write-back triple from the mem/wb pipeline register: destination address, write enable and write data.
- It serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass so decode never sees stale data.
- It also exposes a raw debug read port and a retired-write counter for bring-up and verification.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (index width = 5).
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable, driven by the write-back stage's write-enable flag.
- waddr  input  5  write address, driven by the write-back stage's destination address.
- wdata  input  32  write data, driven by the write-back stage's data.
- re1  input  1  read-port-1 enable.
- raddr1  input  5  read-port-1 address.
- rdata1  output  32  read-port-1 data (combinational).
- re2  input  1  read-port-2 enable.
- raddr2  input  5  read-port-2 address.
- rdata2  output  32  read-port-2 data (combinational).
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  raw array contents at dbg_addr (combinational, no bypass).
- wcount  output  CNT_W  number of retired register writes since reset.

## Operation
- Storage: registers 1..31, 32 bits each. Register 0 has no storage and always reads 0.
- Write: at a posedge with rst=0, we=1 and waddr!=0, the register at waddr takes wdata.
- Writes are ignored when waddr=0; the array and wcount are unchanged.
- Read port n (identical logic for n=1,2), evaluated in priority order:
  - rst=1 → 0.
  - re_n=0 → 0.
  - raddr_n=0 → 0.
  - we=1 and waddr==raddr_n → wdata (bypass).
  - Otherwise → the stored value at raddr_n.
- Both read ports may read the same address, or the address being written, in the same cycle; each applies its own bypass independently.
- dbg_data: 0 when dbg_addr=0, otherwise the raw stored value. It never bypasses and ignores rst gating except through the array itself.
- wcount:
  - Increments by 1 on each accepted write (we=1, waddr!=0, rst=0).
  - Wraps modulo 2^CNT_W with no saturation flag.
  - A write that is ignored because waddr=0 does not increment it.

## Timing
- Reset (asynchronous assert, released synchronously at the board level):
  - All registers 1..31 = 0 and wcount = 0 immediately on rst rising, without waiting for clk.
  - rdata1 = rdata2 = 0 while rst=1.
  - dbg_data = 0 during reset.
- Write latency: data is visible in the array (dbg_data) one posedge after presentation.
- Read ports see new data in the same cycle via bypass.
- Read latency: zero cycles; the read paths are purely combinational from addresses and enables.
- Reset asserted mid-write: the write is lost. After rst deasserts, the first posedge with we=1 performs a normal write.
- No back-pressure. A write is accepted every cycle we=1; back-to-back writes to the same address keep the last value.

## Structure
- Shared package holds:
  - REG_ADDR_W = 5.
  - REG_DATA_W = 32.
  - ZERO_WORD = 32'h00000000.
  - NOP_REG_ADDR = 5'b00000.
  - WRITE_ENABLE / WRITE_DISABLE, READ_ENABLE / READ_DISABLE constants.
- The pipeline registers share these same constants.
- One sub-module is natural: regfile_rport, containing the bypass/priority mux for one read port. It is instantiated twice with identical code to guarantee both ports match.
- The array, write logic, debug port and counter stay in the top module.

## Test plan
- Reset check: pulse rst between clock edges → wcount=0, rdata1=rdata2=0 and dbg_data=0 for every dbg_addr 0..31, all before the next posedge.
- Basic write/read: write 32'hDEADBEEF to r5; next cycle re1=1, raddr1=5 → rdata1=32'hDEADBEEF; wcount=1.
- Bypass: in the same cycle we=1, waddr=7, wdata=32'h12345678, re1=re2=1, raddr1=raddr2=7 → both rdata=32'h12345678 that cycle, while dbg_data at addr 7 is still the old value (0) until the posedge.
- r0 immutability: write 32'hFFFFFFFF to waddr=0 with re1=1, raddr1=0 → rdata1=0 in that cycle and the next; wcount unchanged.
- Read enable gating and mid-write reset:
  - re2=0 with raddr2=5 holding 32'hDEADBEEF → rdata2=0.
  - Assert rst during a write to r9 with value 32'hA5A5A5A5 → r9 reads 0 after reset and wcount=0.
- Counter wrap: with CNT_W=4, perform 17 accepted writes → wcount=1.
